// File: rtl/huffman_decoder_if.sv
// Stream-side bundle for huffman_decoder: packed code words in, decoded symbols out.
interface huffman_decoder_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic [5:0]  last_length;
  logic [7:0]  symbol_out;
  logic        symbol_valid;
  logic        symbol_ready;

  modport master (
    output word_in, word_valid, word_last, last_length, symbol_ready,
    input  word_ready, symbol_out, symbol_valid
  );

  modport slave (
    input  word_in, word_valid, word_last, last_length, symbol_ready,
    output word_ready, symbol_out, symbol_valid
  );
endinterface

// File: rtl/huffman_decoder.sv
// Table-driven Huffman decoder: LSB-first 32-bit words in, one symbol per cycle out.
// HUFFMAN_DECODER_ERR_EN: defined -> sticky ERR state; undefined -> undecodable bits are dropped one at a time.
//
// state | meaning
// IDLE  | no stream in progress; table writable
// RUN   | accepting words and decoding
// DRAIN | final word taken; decoding remaining bits
// ERR   | undecodable input seen; frozen until reset (ERR_EN builds only)
module huffman_decoder #(
  parameter int TBL_DEPTH = 16,
  parameter int MAX_LEN   = 8,
  localparam int AW       = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            ce,
  input  logic            tbl_we,
  input  logic [AW-1:0]   tbl_addr,
  input  logic [7:0]      tbl_code,
  input  logic [3:0]      tbl_len,
  input  logic [7:0]      tbl_sym,
  huffman_decoder_if.slave strm,
  output logic            done,
  output logic            err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
`ifdef HUFFMAN_DECODER_ERR_EN
  localparam logic [1:0] ST_ERR   = 2'd3;
`endif
  localparam logic [5:0] MAX_LEN_C  = 6'(MAX_LEN);
  localparam logic [3:0] MAX_LEN_L4 = 4'(MAX_LEN);

  logic [1:0]  state;
  logic [39:0] bit_buf;
  logic [5:0]  count;
  logic [7:0]  sym_q;
  logic        sym_vld;

  logic [7:0]           tcode [TBL_DEPTH];
  logic [3:0]           tlen  [TBL_DEPTH];
  logic [7:0]           tsym  [TBL_DEPTH];
  logic [TBL_DEPTH-1:0] tvld;

  logic        xfer;
  logic [5:0]  app_len;
  logic [31:0] word_mask;
  logic [39:0] view;
  logic [5:0]  view_cnt;
  logic        hit;
  logic [7:0]  hit_sym;
  logic [3:0]  hit_len;
  logic        active;
  logic        can_emit;
  logic        attempt;
  logic        decode;
  logic        bad;
  logic [5:0]  shift;
  logic [39:0] bits_nxt;
  logic [5:0]  count_nxt;

  function automatic logic [7:0] len_mask(input logic [3:0] len);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) m[b] = (4'(b) < len);
    return m;
  endfunction

  assign active   = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_DRAIN);
  assign strm.word_ready = (count <= 6'd8) && ((state == ST_IDLE) || (state == ST_RUN));
  assign xfer     = ce && strm.word_valid && strm.word_ready;

  // Decoding looks at the buffer with this cycle's word already appended,
  // so the first symbol of a word appears the cycle right after it is taken.
  always_comb begin
    app_len = 6'd0;
    if (xfer) begin
      if (!strm.word_last || strm.last_length > 6'd32) app_len = 6'd32;
      else                                             app_len = strm.last_length;
    end
    word_mask = '0;
    for (int b = 0; b < 32; b++) word_mask[b] = (6'(b) < app_len);
    view     = bit_buf | ({8'd0, strm.word_in & word_mask} << count);
    view_cnt = count + app_len;
  end

  always_comb begin
    hit     = 1'b0;
    hit_sym = 8'd0;
    hit_len = 4'd0;
    for (int i = TBL_DEPTH - 1; i >= 0; i--) begin
      if (tvld[i] && ({2'b00, tlen[i]} <= view_cnt) &&
          (((view[7:0] ^ tcode[i]) & len_mask(tlen[i])) == 8'd0)) begin
        hit     = 1'b1;
        hit_sym = tsym[i];
        hit_len = tlen[i];
      end
    end
  end

  assign can_emit = !sym_vld || strm.symbol_ready;
  assign attempt  = active && can_emit && (view_cnt != 6'd0);
  assign decode   = attempt && hit;
  assign bad      = attempt && !hit && ((view_cnt >= MAX_LEN_C) || (state == ST_DRAIN));

  always_comb begin
    shift = 6'd0;
    if (decode) shift = {2'b00, hit_len};
`ifndef HUFFMAN_DECODER_ERR_EN
    else if (bad) shift = 6'd1;
`endif
  end

  assign bits_nxt  = view >> shift;
  assign count_nxt = view_cnt - shift;

  assign done              = (state == ST_DRAIN) && (count == 6'd0) && !sym_vld;
  assign strm.symbol_out   = sym_q;
  assign strm.symbol_valid = sym_vld;
`ifdef HUFFMAN_DECODER_ERR_EN
  assign err = (state == ST_ERR);
`else
  assign err = 1'b0;
`endif

  // Table payload carries no reset; only the valid bits are cleared.
  always_ff @(posedge clock) begin
    if (resetn && ce && tbl_we && (state == ST_IDLE)) begin
      tcode[tbl_addr] <= tbl_code;
      tlen[tbl_addr]  <= tbl_len;
      tsym[tbl_addr]  <= tbl_sym;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      bit_buf <= '0;
      count   <= '0;
      sym_q   <= 8'd0;
      sym_vld <= 1'b0;
      tvld    <= '0;
    end else if (ce) begin
      bit_buf <= bits_nxt;
      count   <= count_nxt;
      if (decode) begin
        sym_q   <= hit_sym;
        sym_vld <= 1'b1;
      end else if (strm.symbol_ready) begin
        sym_vld <= 1'b0;
      end
      if (tbl_we && (state == ST_IDLE))
        tvld[tbl_addr] <= (tbl_len != 4'd0) && (tbl_len <= MAX_LEN_L4);
      case (state)
        ST_IDLE:  if (xfer) state <= strm.word_last ? ST_DRAIN : ST_RUN;
        ST_RUN:   if (xfer && strm.word_last) state <= ST_DRAIN;
        ST_DRAIN: if (done) state <= ST_IDLE;
        default:  ;
      endcase
`ifdef HUFFMAN_DECODER_ERR_EN
      if (bad) state <= ST_ERR;
`endif
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: small prefix-code table, hand-derived symbol streams.
module tb_huffman_decoder;
  logic       clock = 1'b0;
  logic       resetn;
  logic       ce;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [7:0] tbl_code;
  logic [3:0] tbl_len;
  logic [7:0] tbl_sym;
  logic       done;
  logic       err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0] got_q[$];

  huffman_decoder_if strm();

  huffman_decoder #(.TBL_DEPTH(16), .MAX_LEN(8)) dut (
    .clock(clock),
    .resetn(resetn),
    .ce(ce),
    .tbl_we(tbl_we),
    .tbl_addr(tbl_addr),
    .tbl_code(tbl_code),
    .tbl_len(tbl_len),
    .tbl_sym(tbl_sym),
    .strm(strm),
    .done(done),
    .err(err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetn && ce) begin
      if (strm.symbol_valid && strm.symbol_ready) got_q.push_back(strm.symbol_out);
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    clear_obs();
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] c, input logic [3:0] l, input logic [7:0] s);
    tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l; tbl_sym = s;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic last, input logic [5:0] len);
    bit ok;
    ok = 1'b0;
    strm.word_in = w; strm.word_last = last; strm.last_length = len; strm.word_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (strm.word_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    strm.word_valid = 1'b0;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit ok;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic check_abc(input string tag);
    check({tag, "_n"}, got_q.size(), 3);
    check({tag, "_s0"}, got_q[0], 8'h41);
    check({tag, "_s1"}, got_q[1], 8'h42);
    check({tag, "_s2"}, got_q[2], 8'h43);
  endtask

  task automatic check_all_a(input string tag, input int n);
    int wrong;
    wrong = 0;
    foreach (got_q[i]) if (got_q[i] != 8'h41) wrong++;
    check({tag, "_n"}, got_q.size(), n);
    check({tag, "_sym"}, wrong, 0);
    check({tag, "_done"}, done_cnt, 1);
  endtask

  task automatic load_abc();
    load(4'd0, 8'b0,  4'd1, 8'h41);
    load(4'd1, 8'b01, 4'd2, 8'h42);
    load(4'd2, 8'b11, 4'd2, 8'h43);
  endtask

  initial begin
    resetn = 1'b0; ce = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0; tbl_sym = '0;
    strm.word_in = '0; strm.word_valid = 1'b0; strm.word_last = 1'b0; strm.last_length = '0;
    strm.symbol_ready = 1'b1;
    tick(2);
    resetn = 1'b1;
    clear_obs();

    check("rst_sv", strm.symbol_valid, 0);
    check("rst_sym", strm.symbol_out, 8'h00);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdy", strm.word_ready, 1);

    load_abc();

    // clock enable low: the offered word must not be taken
    ce = 1'b0;
    strm.word_in = 32'h0000001A; strm.word_last = 1'b1; strm.last_length = 6'd5; strm.word_valid = 1'b1;
    tick(3);
    check("ce_hold_sv", strm.symbol_valid, 0);
    check("ce_hold_rdy", strm.word_ready, 1);
    ce = 1'b1;
    tick();
    strm.word_valid = 1'b0;
    check("lat_sv", strm.symbol_valid, 1);
    check("lat_sym", strm.symbol_out, 8'h41);
    wait_done(50);
    check_abc("abc");
    check("abc_err", err, 0);
    tick(3);
    check("done_pulse", done_cnt, 1);

    clear_obs();
    send(32'h0, 1'b0, 6'd0);
    send(32'h0, 1'b1, 6'd0);
    wait_done(100);
    check_all_a("zero32", 32);

    clear_obs();
    send(32'h0, 1'b1, 6'd40);
    wait_done(100);
    check_all_a("clamp", 32);

    // stalled consumer; a table write while busy must be ignored
    clear_obs();
    strm.symbol_ready = 1'b0;
    send(32'h0000001A, 1'b1, 6'd5);
    for (int i = 0; i < 5; i++) begin
      check("stall_sv", strm.symbol_valid, 1);
      check("stall_sym", strm.symbol_out, 8'h41);
      if (i == 2) load(4'd0, 8'b0, 4'd1, 8'h55);
      else tick();
    end
    strm.symbol_ready = 1'b1;
    wait_done(50);
    check_abc("stall");

    clear_obs();
    send(32'h0000001A, 1'b1, 6'd5);
    for (int i = 0; i < 20; i++) begin
      if (got_q.size() >= 2) break;
      tick();
    end
    check("mid_s0", got_q[0], 8'h41);
    strm.symbol_ready = 1'b0;
    resetn = 1'b0;
    tick();
    check("mid_sv", strm.symbol_valid, 0);
    check("mid_sym", strm.symbol_out, 8'h00);
    check("mid_rdy", strm.word_ready, 1);
    check("mid_done", done, 0);
    resetn = 1'b1;
    strm.symbol_ready = 1'b1;
    check("mid_n", got_q.size(), 2);

    // table was invalidated by reset: a lone 1 bit cannot decode
    send(32'h1, 1'b1, 6'd1);
`ifdef HUFFMAN_DECODER_ERR_EN
    tick(4);
    check("inv_err", err, 1);
    check("inv_rdy", strm.word_ready, 0);
`else
    wait_done(20);
    check("inv_err", err, 0);
    check("inv_done", done_cnt, 1);
`endif
    check("inv_n", got_q.size(), 2);

    do_reset();
    load(4'd0, 8'b0,  4'd1, 8'h41);
    load(4'd1, 8'b01, 4'd2, 8'h42);
    send(32'h3, 1'b1, 6'd2);
`ifdef HUFFMAN_DECODER_ERR_EN
    tick(4);
    check("bad_err", err, 1);
    check("bad_rdy", strm.word_ready, 0);
    check("bad_sv", strm.symbol_valid, 0);
`else
    wait_done(20);
    check("bad_err", err, 0);
    check("bad_done", done_cnt, 1);
    check("bad_rdy", strm.word_ready, 1);
`endif
    check("bad_n", got_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 The block SHALL have parameter TBL_DEPTH, default 16, meaning the number of code-table entries (power of two, 2..16).
REQ-002 The block SHALL have parameter MAX_LEN, default 8, meaning the maximum code length in bits (1..8).
REQ-003 clock  input  1  all state updates on the rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low; clock clock.
REQ-005 ce  input  1  clock enable; when 0, all state and outputs hold, except that resetn still applies.
REQ-006 tbl_we, tbl_addr, tbl_code, tbl_len, tbl_sym  input  1/log2(TBL_DEPTH)/8/4/8  table write port: code bits LSB-first, length, decoded symbol.
REQ-007 word_in  input  32  packed code stream word; bit 0 is the earliest bit.
REQ-008 word_valid / word_ready  input / output  1 / 1  word handshake; a transfer occurs when both are 1 with ce=1.
REQ-009 word_last / last_length  input  1 / 6  marks the final word; last_length = number of valid bits in it (0..32; values >32 are treated as 32).
REQ-010 symbol_out / symbol_valid / symbol_ready  output / output / input  8 / 1 / 1  decoded symbol handshake.
REQ-011 done  output  1  one-cycle pulse when the final word is fully decoded.
REQ-012 err  output  1  sticky decode error flag.

Function
REQ-013 States SHALL be IDLE, RUN, DRAIN and ERR.
- IDLE -> RUN on the first word transfer.
- RUN -> DRAIN on a word_last transfer.
- DRAIN -> IDLE with done=1 when bit count = 0 and no symbol is pending.
- RUN/DRAIN -> ERR on a decode error.
REQ-014 The block SHALL keep a 40-bit bit buffer plus a 6-bit count (0..40); valid bits occupy buf[count-1:0], with bit 0 the next to decode.
REQ-015 word_ready SHALL equal (count <= 8) and (state is IDLE or RUN); a non-last transfer appends 32 bits at buf[count+31:count]; a last transfer appends last_length bits and masks the rest to 0.
REQ-016 A table entry SHALL match when it is valid (1 <= len <= MAX_LEN), count >= len, and buf[len-1:0] == code[len-1:0]; on multiple matches, the lowest address wins.
REQ-017 At most one symbol SHALL be decoded per cycle, and only when the symbol_out register is empty or is being consumed in that cycle.
REQ-018 On a decode, symbol_out <= entry sym, symbol_valid <= 1, the buffer shifts right by len, and count decreases by len; a word append in the same cycle lands at the post-shift count.
REQ-019 symbol_out SHALL remain stable while symbol_valid=1 and symbol_ready=0.
REQ-020 Latency: a word accepted in cycle N SHALL give its first symbol valid in cycle N+1.
REQ-021 A decode error SHALL be: no match while (count >= MAX_LEN) or (state = DRAIN and count > 0).
REQ-022 In ERR, word_ready=0 and no decodes occur; the block stays there until reset.
REQ-023 Table writes SHALL take effect only in IDLE and are ignored otherwise; an entry is valid when 1 <= tbl_len <= MAX_LEN.
REQ-024 A word_last transfer with last_length = 0 SHALL go straight to DRAIN; if count = 0, done pulses on the next cycle.

Reset
REQ-025 When resetn=0 at a clock edge, regardless of ce:
- state=IDLE, count=0, buffer=0, all table-valid bits=0;
- symbol_valid=0, symbol_out=0x00, done=0, err=0.
REQ-026 Reset mid-stream SHALL discard the buffered bits and any pending symbol in the same cycle.

Configuration
REQ-027 Macro HUFFMAN_DECODER_ERR_EN SHALL select the decode-error behaviour.
- Defined: ERR state and err output behave per REQ-021/022.
- Undefined: ERR state is removed and err is tied 0; on a REQ-021 condition the block discards 1 buffer bit (count-1) and continues.

Verification
REQ-028 Table {0: code 0b0 len 1 sym 0x41; 1: code 0b01 len 2 sym 0x42; 2: code 0b11 len 2 sym 0x43}; word 0x0000001A, last, last_length 5 -> symbols 0x41, 0x42, 0x43, then done pulse, err=0.
REQ-029 Same table; word 0x00000000 non-last, then word 0 last, last_length 0 -> 32 symbols of 0x41, then done.
REQ-030 Table entries 0 and 1 only; word 0x00000003, last, last_length 2 -> no symbol, err=1, word_ready=0 (with ERR_EN); without ERR_EN -> two bits dropped, done, err=0.
REQ-031 Stream of REQ-028 with symbol_ready held 0 for 5 cycles -> symbol_out=0x41 stable with symbol_valid=1; sequence resumes unchanged.
REQ-032 resetn=0 asserted after the second symbol of REQ-028 -> next cycle symbol_valid=0, count=0, state IDLE, table invalid.
